alu_seq: RTL and testbench

//  Clocked, parametrised successor to the core's latch-based ALU. Takes operands on a start strobe and

---
 rtl/alu_seq_if.sv | 37 +++
 rtl/alu_seq.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle between the instruction sequencer and alu_seq.
//   master modport: sequencer side (drives the operation, consumes result/flags, acks PSR update)
//   slave  modport: ALU side
// Signals:
//   start, op_sel[3:0], a_in, b_in, c_in, d_in, psr_in[7:0]  -> operation request
//   busy, done, result, n/v/z/c_result                      <- operation response
//   psr_update_request / ack_update_request                  PSR update handshake
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [3:0]       op_sel;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic             d_in;
  logic [7:0]       psr_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             n_result;
  logic             v_result;
  logic             z_result;
  logic             c_result;
  logic             psr_update_request;
  logic             ack_update_request;

  modport master (
    output start, op_sel, a_in, b_in, c_in, d_in, psr_in, ack_update_request,
    input  busy, done, result, n_result, v_result, z_result, c_result, psr_update_request
  );

  modport slave (
    input  start, op_sel, a_in, b_in, c_in, d_in, psr_in, ack_update_request,
    output busy, done, result, n_result, v_result, z_result, c_result, psr_update_request
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: clocked ALU. Binary ops complete in one cycle; decimal ADC/SBC run
// one BCD digit per cycle, least significant digit first (65C02 semantics).
// Ports:
//   mem_clk  clock, all state on rising edge
//   resb     asynchronous active-low reset
//   bus      alu_seq_if.slave: operation request, result/flags, PSR update handshake
// Timing: binary result and done appear the cycle after start is sampled (the
// EXEC cycle, which also accepts a new start). Decimal ops stay in DEC for
// NIB cycles and raise done on return to IDLE.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic     mem_clk,
  input  logic     resb,
  alu_seq_if.slave bus
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = $clog2(NIB + 1);
  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_ORA = 4'h1;
  localparam logic [3:0] OP_EOR = 4'h2;
  localparam logic [3:0] OP_ADC = 4'h3;
  localparam logic [3:0] OP_SBC = 4'h4;
  localparam logic [3:0] OP_ASL = 4'h5;
  localparam logic [3:0] OP_LSR = 4'h6;
  localparam logic [3:0] OP_ROL = 4'h7;
  localparam logic [3:0] OP_ROR = 4'h8;
  localparam logic [3:0] OP_BIT = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_TSB = 4'hB;
  localparam logic [3:0] OP_TRB = 4'hC;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DEC  = 2'd2
  } state_t;

  // One BCD digit step; returns {carry_out, digit}. For SBC the carry means "no borrow".
  // Only the low nibble matters, so the +/-6 correction is done mod 16.
  function automatic logic [4:0] bcd_digit(input logic [3:0] a_d, input logic [3:0] b_d,
                                           input logic cy, input logic sub);
    logic [5:0] s;
    if (sub) begin
      s = {2'b00, a_d} - {2'b00, b_d} - {5'b00000, ~cy};
      if (s[5]) begin
        return {1'b0, s[3:0] - 4'd6};
      end else begin
        return {1'b1, s[3:0]};
      end
    end else begin
      s = {2'b00, a_d} + {2'b00, b_d} + {5'b00000, cy};
      if (s > 6'd9) begin
        return {1'b1, s[3:0] + 4'd6};
      end else begin
        return {1'b0, s[3:0]};
      end
    end
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cy_q, cy_d;
  logic             sub_q, sub_d;
  logic             dv_q, dv_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             n_q, n_d, v_q, v_d, z_q, z_d, c_q, c_d;
  logic             req_q, req_d;

  logic [WIDTH-1:0] bop_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic             add_v_s;
  logic             and_z_s;
  logic [WIDTH-1:0] bin_res_s;
  logic             bin_n_s, bin_v_s, bin_z_s, bin_c_s;
  logic             is_dec_s;
  logic [4:0]       digit_s;
  logic [WIDTH-1:0] acc_next_s;
  logic             unused_psr_s;

  // B, D, I and the constant bit of the PSR never feed a result flag.
  assign unused_psr_s = ^bus.psr_in[5:2];

  // Single-cycle result and flags for every op, straight from the request inputs.
  always_comb begin
    // SBC is ADC of the one's complement; V for decimal ops reuses this path too.
    bop_s     = (bus.op_sel == OP_SBC) ? ~bus.b_in : bus.b_in;
    sum_s     = {1'b0, bus.a_in} + {1'b0, bop_s} + {{WIDTH{1'b0}}, bus.c_in};
    add_v_s   = (bus.a_in[MSB] == bop_s[MSB]) && (sum_s[MSB] != bus.a_in[MSB]);
    diff_s    = {1'b0, bus.a_in} - {1'b0, bus.b_in};
    and_z_s   = ((bus.a_in & bus.b_in) == {WIDTH{1'b0}});
    bin_res_s = bus.a_in;
    bin_n_s   = bus.psr_in[7];
    bin_v_s   = bus.psr_in[6];
    bin_z_s   = bus.psr_in[1];
    bin_c_s   = bus.psr_in[0];
    case (bus.op_sel)
      OP_AND, OP_ORA, OP_EOR: begin
        if (bus.op_sel == OP_AND) begin
          bin_res_s = bus.a_in & bus.b_in;
        end else if (bus.op_sel == OP_ORA) begin
          bin_res_s = bus.a_in | bus.b_in;
        end else begin
          bin_res_s = bus.a_in ^ bus.b_in;
        end
        bin_n_s = bin_res_s[MSB];
        bin_z_s = (bin_res_s == {WIDTH{1'b0}});
      end
      OP_ADC, OP_SBC: begin
        bin_res_s = sum_s[MSB:0];
        bin_n_s   = sum_s[MSB];
        bin_z_s   = (sum_s[MSB:0] == {WIDTH{1'b0}});
        bin_v_s   = add_v_s;
        bin_c_s   = sum_s[WIDTH];
      end
      OP_ASL, OP_ROL: begin
        bin_res_s = {bus.b_in[MSB-1:0], (bus.op_sel == OP_ROL) ? bus.c_in : 1'b0};
        bin_n_s   = bin_res_s[MSB];
        bin_z_s   = (bin_res_s == {WIDTH{1'b0}});
        bin_c_s   = bus.b_in[MSB];
      end
      OP_LSR, OP_ROR: begin
        bin_res_s = {(bus.op_sel == OP_ROR) ? bus.c_in : 1'b0, bus.b_in[MSB:1]};
        bin_n_s   = bin_res_s[MSB];
        bin_z_s   = (bin_res_s == {WIDTH{1'b0}});
        bin_c_s   = bus.b_in[0];
      end
      OP_BIT: begin
        bin_res_s = bus.b_in;
        bin_n_s   = bus.b_in[MSB];
        bin_v_s   = bus.b_in[MSB-1];
        bin_z_s   = and_z_s;
      end
      OP_CMP: begin
        bin_res_s = bus.a_in;
        bin_n_s   = diff_s[MSB];
        bin_z_s   = (diff_s[MSB:0] == {WIDTH{1'b0}});
        bin_c_s   = ~diff_s[WIDTH];
      end
      OP_TSB, OP_TRB: begin
        bin_res_s = (bus.op_sel == OP_TSB) ? (bus.a_in | bus.b_in) : (~bus.a_in & bus.b_in);
        bin_z_s   = and_z_s;
      end
      default: begin
        bin_res_s = bus.a_in;
      end
    endcase
  end

  // Next-state logic for the sequencer, decimal datapath and registered outputs.
  always_comb begin
    is_dec_s   = bus.d_in && ((bus.op_sel == OP_ADC) || (bus.op_sel == OP_SBC));
    digit_s    = bcd_digit(a_q[3:0], b_q[3:0], cy_q, sub_q);
    acc_next_s = {digit_s[3:0], acc_q[MSB:4]};
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    cy_d       = cy_q;
    sub_d      = sub_q;
    dv_d       = dv_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;
    n_d        = n_q;
    v_d        = v_q;
    z_d        = z_q;
    c_d        = c_q;
    case (state_q)
      // EXEC is the done cycle of a binary op, so it accepts a new start like IDLE.
      ST_IDLE, ST_EXEC: begin
        if (bus.start) begin
          a_d   = bus.a_in;
          b_d   = bus.b_in;
          cy_d  = bus.c_in;
          sub_d = (bus.op_sel == OP_SBC);
          dv_d  = bin_v_s;
          acc_d = {WIDTH{1'b0}};
          cnt_d = {CW{1'b0}};
          busy_d = 1'b1;
          if (is_dec_s) begin
            state_d = ST_DEC;
          end else begin
            state_d  = ST_EXEC;
            done_d   = 1'b1;
            result_d = bin_res_s;
            n_d      = bin_n_s;
            v_d      = bin_v_s;
            z_d      = bin_z_s;
            c_d      = bin_c_s;
          end
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      // Operands shift right one digit per cycle; result digits enter from the top.
      ST_DEC: begin
        a_d   = {4'b0000, a_q[MSB:4]};
        b_d   = {4'b0000, b_q[MSB:4]};
        cy_d  = digit_s[4];
        acc_d = acc_next_s;
        cnt_d = cnt_q + CW'(1'b1);
        if (cnt_q == CW'(NIB - 1)) begin
          state_d  = ST_IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = acc_next_s;
          n_d      = acc_next_s[MSB];
          v_d      = dv_q;
          z_d      = (acc_next_s == {WIDTH{1'b0}});
          c_d      = digit_s[4];
        end else begin
          state_d = ST_DEC;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
    // A new done wins over a simultaneous ack; ack with no request pending is a no-op.
    if (done_d) begin
      req_d = 1'b1;
    end else if (bus.ack_update_request) begin
      req_d = 1'b0;
    end else begin
      req_d = req_q;
    end
  end

  // State and output registers; reset aborts any op in flight without a done.
  always_ff @(posedge mem_clk or negedge resb) begin
    if (!resb) begin
      state_q  <= ST_IDLE;
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      acc_q    <= {WIDTH{1'b0}};
      cnt_q    <= {CW{1'b0}};
      cy_q     <= 1'b0;
      sub_q    <= 1'b0;
      dv_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= {WIDTH{1'b0}};
      n_q      <= 1'b0;
      v_q      <= 1'b0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      cy_q     <= cy_d;
      sub_q    <= sub_d;
      dv_q     <= dv_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      n_q      <= n_d;
      v_q      <= v_d;
      z_q      <= z_d;
      c_q      <= c_d;
      req_q    <= req_d;
    end
  end

  assign bus.busy               = busy_q;
  assign bus.done               = done_q;
  assign bus.result             = result_q;
  assign bus.n_result           = n_q;
  assign bus.v_result           = v_q;
  assign bus.z_result           = z_q;
  assign bus.c_result           = c_q;
  assign bus.psr_update_request = req_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed, table-driven bench for alu_seq at WIDTH=8 plus a WIDTH=16 instance
// for multi-digit decimal and mid-operation reset.
module tb_alu_seq;
  logic mem_clk = 1'b0;
  logic resb;

  alu_seq_if #(.WIDTH(8))  if8();
  alu_seq_if #(.WIDTH(16)) if16();

  alu_seq #(.WIDTH(8))  dut8  (.mem_clk(mem_clk), .resb(resb), .bus(if8));
  alu_seq #(.WIDTH(16)) dut16 (.mem_clk(mem_clk), .resb(resb), .bus(if16));

  always #5 mem_clk = ~mem_clk;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic       d;
    logic [7:0] psr;
    logic [7:0] res;
    logic [3:0] nvzc;
    int         lat;
    int         busy;
  } vec_t;

  vec_t vecs[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] flags8();
    return {if8.n_result, if8.v_result, if8.z_result, if8.c_result};
  endfunction

  function automatic logic [3:0] flags16();
    return {if16.n_result, if16.v_result, if16.z_result, if16.c_result};
  endfunction

  task automatic drive8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic d, input logic [7:0] psr);
    if8.op_sel = op;
    if8.a_in   = a;
    if8.b_in   = b;
    if8.c_in   = c;
    if8.d_in   = d;
    if8.psr_in = psr;
  endtask

  task automatic run8(input vec_t v, input int idx, input bit do_ack);
    int lat;
    int bcnt;
    @(negedge mem_clk);
    drive8(v.op, v.a, v.b, v.c, v.d, v.psr);
    if8.start = 1'b1;
    @(negedge mem_clk);
    if8.start = 1'b0;
    lat  = 1;
    bcnt = 0;
    while (!if8.done && lat < 20) begin
      bcnt += int'(if8.busy);
      @(negedge mem_clk);
      lat++;
    end
    bcnt += int'(if8.busy);
    chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
    chk($sformatf("v%0d busy cycles", idx), 32'(bcnt), 32'(v.busy));
    chk($sformatf("v%0d result", idx), 32'(if8.result), 32'(v.res));
    chk($sformatf("v%0d nvzc", idx), 32'(flags8()), 32'(v.nvzc));
    chk($sformatf("v%0d req set", idx), 32'(if8.psr_update_request), 32'h1);
    if (do_ack) begin
      if8.ack_update_request = 1'b1;
      @(negedge mem_clk);
      if8.ack_update_request = 1'b0;
      chk($sformatf("v%0d req cleared", idx), 32'(if8.psr_update_request), 32'h0);
      chk($sformatf("v%0d done pulse", idx), 32'(if8.done), 32'h0);
      chk($sformatf("v%0d result held", idx), 32'(if8.result), 32'(v.res));
    end
  endtask

  initial begin
    int lat;
    int dcnt;
    //          op     a      b      c     d     psr    res    nvzc     lat busy
    vecs[0]  = '{4'h3, 8'h50, 8'h50, 1'b0, 1'b0, 8'h00, 8'hA0, 4'b1100, 1, 1};
    vecs[1]  = '{4'h3, 8'h58, 8'h46, 1'b1, 1'b1, 8'h00, 8'h05, 4'b0101, 3, 2};
    vecs[2]  = '{4'h4, 8'h00, 8'h01, 1'b1, 1'b1, 8'h00, 8'h99, 4'b1000, 3, 2};
    vecs[3]  = '{4'h4, 8'h00, 8'h01, 1'b1, 1'b0, 8'h00, 8'hFF, 4'b1000, 1, 1};
    vecs[4]  = '{4'hA, 8'h10, 8'h10, 1'b0, 1'b0, 8'h40, 8'h10, 4'b0111, 1, 1};
    vecs[5]  = '{4'h8, 8'h00, 8'h01, 1'b1, 1'b0, 8'h00, 8'h80, 4'b1001, 1, 1};
    vecs[6]  = '{4'h6, 8'h00, 8'h01, 1'b0, 1'b0, 8'h40, 8'h00, 4'b0111, 1, 1};
    vecs[7]  = '{4'hC, 8'h0F, 8'hFF, 1'b0, 1'b0, 8'hC3, 8'hF0, 4'b1101, 1, 1};
    vecs[8]  = '{4'h0, 8'hF0, 8'h3C, 1'b0, 1'b0, 8'h41, 8'h30, 4'b0101, 1, 1};
    vecs[9]  = '{4'h1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 4'b0010, 1, 1};
    vecs[10] = '{4'h2, 8'hFF, 8'h0F, 1'b0, 1'b0, 8'h00, 8'hF0, 4'b1000, 1, 1};
    vecs[11] = '{4'h5, 8'h00, 8'h81, 1'b0, 1'b0, 8'h00, 8'h02, 4'b0001, 1, 1};
    vecs[12] = '{4'h7, 8'h00, 8'h80, 1'b0, 1'b0, 8'h00, 8'h00, 4'b0011, 1, 1};
    vecs[13] = '{4'h9, 8'h0F, 8'hC0, 1'b0, 1'b0, 8'h01, 8'hC0, 4'b1111, 1, 1};
    vecs[14] = '{4'hB, 8'h01, 8'h02, 1'b0, 1'b0, 8'h80, 8'h03, 4'b1010, 1, 1};
    vecs[15] = '{4'hD, 8'h5A, 8'h00, 1'b0, 1'b0, 8'h83, 8'h5A, 4'b1011, 1, 1};
    vecs[16] = '{4'h3, 8'h99, 8'h01, 1'b0, 1'b1, 8'h00, 8'h00, 4'b0011, 3, 2};
    vecs[17] = '{4'h3, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00, 4'b0011, 1, 1};
    vecs[18] = '{4'h4, 8'h80, 8'h01, 1'b1, 1'b0, 8'h00, 8'h7F, 4'b0101, 1, 1};
    vecs[19] = '{4'h4, 8'h50, 8'h25, 1'b0, 1'b1, 8'h00, 8'h24, 4'b0001, 3, 2};
    vecs[20] = '{4'h3, 8'hAA, 8'h00, 1'b0, 1'b1, 8'h00, 8'h10, 4'b0001, 3, 2};
    vecs[21] = '{4'h0, 8'hFF, 8'h0F, 1'b0, 1'b1, 8'h00, 8'h0F, 4'b0000, 1, 1};

    if8.start = 1'b0;  if8.ack_update_request = 1'b0;
    drive8(4'h0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
    if16.start = 1'b0; if16.ack_update_request = 1'b0;
    if16.op_sel = 4'h0; if16.a_in = 16'h0000; if16.b_in = 16'h0000;
    if16.c_in = 1'b0;  if16.d_in = 1'b0;  if16.psr_in = 8'h00;
    resb = 1'b0;

    // Reset state
    repeat (3) @(negedge mem_clk);
    chk("rst busy", 32'(if8.busy), 32'h0);
    chk("rst done", 32'(if8.done), 32'h0);
    chk("rst result", 32'(if8.result), 32'h0);
    chk("rst flags", 32'(flags8()), 32'h0);
    chk("rst req", 32'(if8.psr_update_request), 32'h0);
    chk("rst result16", 32'(if16.result), 32'h0);
    resb = 1'b1;

    for (int i = 0; i < 22; i++) begin
      run8(vecs[i], i, 1'b1);
    end

    // CMP with ack held low: request persists, falls the cycle after ack
    run8(vecs[4], 100, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge mem_clk);
      chk($sformatf("hold req %0d", k), 32'(if8.psr_update_request), 32'h1);
    end
    // New done and ack in the same cycle: set wins
    drive8(4'h0, 8'hF0, 8'h3C, 1'b0, 1'b0, 8'h00);
    if8.start = 1'b1;
    if8.ack_update_request = 1'b1;
    @(negedge mem_clk);
    if8.start = 1'b0;
    if8.ack_update_request = 1'b0;
    chk("setwins done", 32'(if8.done), 32'h1);
    chk("setwins req", 32'(if8.psr_update_request), 32'h1);
    chk("setwins result", 32'(if8.result), 32'h30);
    if8.ack_update_request = 1'b1;
    @(negedge mem_clk);
    if8.ack_update_request = 1'b0;
    chk("ack after hold", 32'(if8.psr_update_request), 32'h0);

    // Ack with no request pending does nothing
    if8.ack_update_request = 1'b1;
    repeat (2) @(negedge mem_clk);
    if8.ack_update_request = 1'b0;
    chk("idle ack req", 32'(if8.psr_update_request), 32'h0);
    chk("idle ack done", 32'(if8.done), 32'h0);

    // Start while busy in DEC is ignored
    @(negedge mem_clk);
    drive8(4'h3, 8'h58, 8'h46, 1'b1, 1'b1, 8'h00);
    if8.start = 1'b1;
    @(negedge mem_clk);
    chk("busy in dec", 32'(if8.busy), 32'h1);
    drive8(4'h0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
    @(negedge mem_clk);
    if8.start = 1'b0;
    @(negedge mem_clk);
    chk("ignore done", 32'(if8.done), 32'h1);
    chk("ignore result", 32'(if8.result), 32'h05);
    chk("ignore carry", 32'(if8.c_result), 32'h1);
    @(negedge mem_clk);
    chk("ignore no 2nd done", 32'(if8.done), 32'h0);
    chk("ignore idle", 32'(if8.busy), 32'h0);
    if8.ack_update_request = 1'b1;
    @(negedge mem_clk);
    if8.ack_update_request = 1'b0;

    // Start in the done cycle is accepted
    drive8(4'h2, 8'hFF, 8'h0F, 1'b0, 1'b0, 8'h00);
    if8.start = 1'b1;
    @(negedge mem_clk);
    chk("b2b first done", 32'(if8.done), 32'h1);
    chk("b2b first result", 32'(if8.result), 32'hF0);
    drive8(4'h1, 8'h01, 8'h02, 1'b0, 1'b0, 8'h00);
    @(negedge mem_clk);
    if8.start = 1'b0;
    chk("b2b second done", 32'(if8.done), 32'h1);
    chk("b2b second result", 32'(if8.result), 32'h03);
    @(negedge mem_clk);
    chk("b2b then quiet", 32'(if8.done), 32'h0);
    if8.ack_update_request = 1'b1;
    @(negedge mem_clk);
    if8.ack_update_request = 1'b0;

    // WIDTH=16 decimal: 9999 + 0001 -> 0000, C1 Z1, four digit cycles
    if16.op_sel = 4'h3; if16.a_in = 16'h9999; if16.b_in = 16'h0001;
    if16.c_in = 1'b0; if16.d_in = 1'b1; if16.psr_in = 8'h00;
    if16.start = 1'b1;
    @(negedge mem_clk);
    if16.start = 1'b0;
    lat = 1;
    while (!if16.done && lat < 20) begin
      @(negedge mem_clk);
      lat++;
    end
    chk("w16 dec latency", 32'(lat), 32'd5);
    chk("w16 dec result", 32'(if16.result), 32'h0000);
    chk("w16 dec nvzc", 32'(flags16()), 32'h3);

    // WIDTH=16 binary overflow: 7FFF + 0001
    if16.a_in = 16'h7FFF; if16.d_in = 1'b0;
    if16.start = 1'b1;
    @(negedge mem_clk);
    if16.start = 1'b0;
    chk("w16 bin done", 32'(if16.done), 32'h1);
    chk("w16 bin result", 32'(if16.result), 32'h8000);
    chk("w16 bin nvzc", 32'(flags16()), 32'hC);
    chk("w16 req", 32'(if16.psr_update_request), 32'h1);

    // Reset mid-DEC aborts: outputs 0 and no done afterwards
    @(negedge mem_clk);
    if16.a_in = 16'h1234; if16.b_in = 16'h4321; if16.d_in = 1'b1;
    if16.start = 1'b1;
    @(negedge mem_clk);
    if16.start = 1'b0;
    @(negedge mem_clk);
    chk("abort busy before", 32'(if16.busy), 32'h1);
    #2 resb = 1'b0;
    #1;
    chk("abort busy", 32'(if16.busy), 32'h0);
    chk("abort done", 32'(if16.done), 32'h0);
    chk("abort result", 32'(if16.result), 32'h0);
    chk("abort flags", 32'(flags16()), 32'h0);
    chk("abort req", 32'(if16.psr_update_request), 32'h0);
    @(negedge mem_clk);
    resb = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge mem_clk);
      dcnt += int'(if16.done) + int'(if16.busy);
    end
    chk("abort no done", 32'(dcnt), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
